// File: rtl/rca_seq_ctrl_pkg.sv
// rca_seq_pkg: shared state encoding and slice width for the nibble-serial adder.
package rca_seq_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;
endpackage

// File: rtl/rca_seq_ctrl_if.sv
// rca_seq_ctrl_if: operand/result handshakes of the nibble-serial adder.
// ovf exists only when RCA_SEQ_OVF_EN is defined.
interface rca_seq_ctrl_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef RCA_SEQ_OVF_EN
    logic             ovf;
    modport master (output in_valid, a, b, cin, out_ready,
                    input in_ready, out_valid, sum, cout, busy, ovf);
    modport slave  (input in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, busy, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input in_ready, out_valid, sum, cout, busy);
    modport slave  (input in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/rca_seq_ctrl_nibble.sv
// rca_nibble: 4-bit ripple-carry slice of four full adders; c3 is the carry into bit 3.
import rca_seq_pkg::*;
module rca_nibble (
    input  logic [NIB_W-1:0] i_a4,
    input  logic [NIB_W-1:0] i_b4,
    input  logic             i_ci,
    output logic [NIB_W-1:0] o_s4,
    output logic             o_co,
    output logic             o_c3
);
    logic [NIB_W:0] w_c;
    assign w_c[0] = i_ci;
    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign o_s4[i]    = i_a4[i] ^ i_b4[i] ^ w_c[i];
        assign w_c[i+1]   = (i_a4[i] & i_b4[i]) | (w_c[i] & (i_a4[i] ^ i_b4[i]));
    end
    assign o_co = w_c[NIB_W];
    assign o_c3 = w_c[NIB_W-1];
endmodule

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: nibble-serial WIDTH-bit adder on one shared 4-bit ripple slice.
// Define RCA_SEQ_OVF_EN to add the registered signed-overflow output.
import rca_seq_pkg::*;
module rca_seq_ctrl #(parameter int WIDTH = 16) (
    input  logic          clk,
    input  logic          rst_n,
    rca_seq_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / NIB_W;
    localparam int IW  = $clog2(NIB);
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [IW-1:0]    r_idx;
    logic             r_carry, r_cout;
    logic [NIB_W-1:0] w_s4;
    logic             w_co, w_c3, w_last;
    assign w_last = r_idx == IW'(NIB - 1);
    rca_nibble u_nib (
        .i_a4 (r_a[NIB_W*r_idx +: NIB_W]),
        .i_b4 (r_b[NIB_W*r_idx +: NIB_W]),
        .i_ci (r_carry),
        .o_s4 (w_s4),
        .o_co (w_co),
        .o_c3 (w_c3)
    );
`ifdef RCA_SEQ_OVF_EN
    logic r_ovf;
    assign bus.ovf = r_ovf;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (r_state == S_RUN && w_last)
            r_ovf <= w_c3 ^ w_co;
`else
    logic w_unused;
    assign w_unused = w_c3;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_a     <= bus.a;
                    r_b     <= bus.b;
                    r_carry <= bus.cin;
                    r_idx   <= '0;
                    r_sum   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_sum[NIB_W*r_idx +: NIB_W] <= w_s4;
                    r_carry <= w_co;
                    r_idx   <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        r_cout  <= w_co;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: if (bus.out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    // Handshake flags come straight from the state register: no input-to-output path.
    assign bus.in_ready  = r_state == S_IDLE;
    assign bus.out_valid = r_state == S_DONE;
    assign bus.busy      = r_state == S_RUN || r_state == S_DONE;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule
